// File: rtl/dm_pipe_mem.sv
// dm_pipe_mem: MEM-stage data memory with req/rsp handshake, configurable access latency and a post-reset clear sweep.
// Optional store trace is compiled in when DM_TRACE_EN is defined.
module dm_pipe_mem #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = 4;

  localparam logic [2:0] DM_W  = 3'd0;
  localparam logic [2:0] DM_H  = 3'd1;
  localparam logic [2:0] DM_HU = 3'd2;
  localparam logic [2:0] DM_B  = 3'd3;
  localparam logic [2:0] DM_BU = 3'd4;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_BUSY  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [2:0]        type_q, type_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [31:0]       mem_q [DEPTH];
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_idx_s;
  logic [31:0]       mem_wdata_s;
  logic [3:0]        mem_be_s;

  logic              acc_err_s;
  logic              commit_s;
  logic [31:0]       rd_word_s;
  logic [31:0]       load_s;

  function automatic logic access_err(input logic [2:0] t, input logic [31:0] a);
    logic bad_type;
    logic misalign;
    logic out_of_range;
    bad_type     = (t > DM_BU);
    misalign     = ((t == DM_W) && (a[1:0] != 2'b00)) ||
                   (((t == DM_H) || (t == DM_HU)) && a[0]);
    out_of_range = ((a >> (ADDR_W + 2)) != 32'd0);
    return bad_type || misalign || out_of_range;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] t, input logic [31:0] word,
                                              input logic [1:0] off);
    logic [31:0] lane;
    logic [31:0] res;
    lane = word >> {off, 3'b000};
    case (t)
      DM_W:    res = word;
      DM_H:    res = {{16{lane[15]}}, lane[15:0]};
      DM_HU:   res = {16'd0, lane[15:0]};
      DM_B:    res = {{24{lane[7]}}, lane[7:0]};
      DM_BU:   res = {24'd0, lane[7:0]};
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  assign rd_word_s = mem_q[addr_q[ADDR_W+1:2]];
  assign acc_err_s = access_err(type_q, addr_q);
  assign load_s    = load_extend(type_q, rd_word_s, addr_q[1:0]);
  assign commit_s  = (state_q == S_BUSY) && (cnt_q == CNT_W'(0));

  assign req_ready = ready_q;
  assign rsp_valid = valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Next-state, capture and array write-port selection
  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    type_d      = type_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ready_d     = 1'b0;
    valid_d     = 1'b0;
    err_d       = err_q;
    rdata_d     = rdata_q;
    mem_we_s    = 1'b0;
    mem_idx_s   = addr_q[ADDR_W+1:2];
    mem_wdata_s = 32'd0;
    mem_be_s    = 4'b0000;

    case (state_q)
      S_CLEAR: begin
        mem_we_s  = 1'b1;
        mem_idx_s = clr_idx_q;
        mem_be_s  = 4'b1111;
        clr_idx_d = clr_idx_q + ADDR_W'(1);
        if (clr_idx_q == ADDR_W'(DEPTH - 1)) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end else begin
          state_d = S_CLEAR;
        end
      end
      S_IDLE: begin
        if (req_valid && ready_q) begin
          we_d    = req_we;
          type_d  = req_type;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = S_BUSY;
        end else begin
          ready_d = 1'b1;
        end
      end
      S_BUSY: begin
        if (cnt_q != CNT_W'(0)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = S_RESP;
          valid_d = 1'b1;
          err_d   = acc_err_s;
          rdata_d = (acc_err_s || we_q) ? 32'd0 : load_s;
          // Stores replicate the low lane(s) so the byte enables pick the addressed one
          case (type_q)
            DM_W: begin
              mem_be_s    = 4'b1111;
              mem_wdata_s = wdata_q;
            end
            DM_H, DM_HU: begin
              mem_be_s    = addr_q[1] ? 4'b1100 : 4'b0011;
              mem_wdata_s = {2{wdata_q[15:0]}};
            end
            DM_B, DM_BU: begin
              mem_be_s    = 4'b0001 << addr_q[1:0];
              mem_wdata_s = {4{wdata_q[7:0]}};
            end
            default: begin
              mem_be_s    = 4'b0000;
              mem_wdata_s = 32'd0;
            end
          endcase
          mem_we_s = we_q && !acc_err_s;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
        ready_d = 1'b1;
      end
      default: begin
        state_d   = S_CLEAR;
        clr_idx_d = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_CLEAR;
      clr_idx_q <= {ADDR_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      we_q      <= 1'b0;
      type_q    <= 3'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      type_q    <= type_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  // Byte-enabled array write; contents are zeroed by the sweep rather than by reset
  always_ff @(posedge clk) begin
    if (mem_we_s && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be_s[i]) begin
          mem_q[mem_idx_s][8*i +: 8] <= mem_wdata_s[8*i +: 8];
        end
      end
    end
  end

`ifdef DM_TRACE_EN
  logic [31:0] pc_q;

  // Captures the requesting PC alongside the other request fields
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= 32'd0;
    end else if ((state_q == S_IDLE) && req_valid && ready_q) begin
      pc_q <= req_pc;
    end
  end

  // Store trace on every committed non-error store
  always_ff @(posedge clk) begin
    if (!reset && commit_s && we_q && !acc_err_s) begin
      $display("%d@%h: *%h <= %h", $time, pc_q, addr_q, wdata_q);
    end
  end
`else
  logic unused_pc_s;
  assign unused_pc_s = ^req_pc;
`endif

endmodule
